// File: rtl/serial_lcd_cmd_pkg.sv
// Shared helpers and types for the serial-to-LCD command path.
// libstd carries generic utilities; liblcd carries the parser state type and control codes.
package libstd;

   // Address width for n entries; never less than one bit.
   function automatic int log2x(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

package liblcd;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WRITE   = 3'd1,
      CLEAR   = 3'd2,
      ESC_ROW = 3'd3,
      ESC_COL = 3'd4
   } lcd_parse_state_t;

   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_ESC   = 8'h1B;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_TILDE = 8'h7E;

   function automatic logic is_printable(input logic [7:0] b);
      return (b >= CH_SPACE) && (b <= CH_TILDE);
   endfunction

endpackage

// File: rtl/serial_lcd_cmd_if.sv
// LCD frame-buffer write port: one cell write per valid/ready handshake.
interface serial_lcd_cmd_if #(
   parameter int AW = 5
) ();

   logic          wr_val;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_char;

   modport master (
      output wr_val,
      output wr_addr,
      output wr_char,
      input  wr_ready
   );

   modport slave (
      input  wr_val,
      input  wr_addr,
      input  wr_char,
      output wr_ready
   );

endinterface

// File: rtl/serial_lcd_cmd_fifo.sv
// Small byte FIFO between the free-running receiver and the parser.
// Head entry is visible on dout without a pop; a push while full is taken only if a pop frees the slot.
module serial_byte_fifo
   import libstd::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = log2x(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset; the pointers define which entries are meaningful.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= din;
   end

endmodule

// File: rtl/serial_lcd_cmd.sv
// Terminal-style byte parser: buffers received bytes and turns them into LCD cell writes.
// Handles printable chars, CR, LF, FF (clear screen) and ESC row col (cursor set).
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | pop and decode the next byte
//   WRITE   | one character write pending on the LCD port
//   CLEAR   | sweeping spaces over every cell
//   ESC_ROW | next byte is the cursor row argument
//   ESC_COL | next byte is the cursor column argument
module serial_lcd_cmd
   import libstd::*;
   import liblcd::*;
#(
   parameter int ROWS       = 2,
   parameter int COLS       = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    rx_val,
   input  logic [7:0]              rx_bits,
   input  logic                    rx_error,
   input  logic                    clr_flags,
   serial_lcd_cmd_if.master        wr,
   output logic                    overflow,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int AW = log2x(ROWS * COLS);
   localparam int RW = log2x(ROWS);
   localparam int CW = log2x(COLS);

   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
   localparam logic [AW-1:0] CLR_LAST = AW'(ROWS * COLS - 1);
   localparam logic [AW-1:0] COLS_AW  = AW'(COLS);
   localparam logic [31:0]   ROW_MAX  = 32'(ROWS - 1);
   localparam logic [31:0]   COL_MAX  = 32'(COLS - 1);

   lcd_parse_state_t state_q, state_d;

   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic [AW-1:0] clr_idx_q, clr_idx_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    char_q, char_d;
   logic          wr_val_q, wr_val_d;
   logic          overflow_q, frame_err_q;

   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic          pop;
   logic          wr_hs;
   logic [RW-1:0] row_inc;
   logic [AW-1:0] cur_addr;
   logic [31:0]   arg;

   serial_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_val),
      .din   (rx_bits),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign pop      = !fifo_empty &&
                     ((state_q == IDLE) || (state_q == ESC_ROW) || (state_q == ESC_COL));
   assign wr_hs    = wr_val_q && wr.wr_ready;
   assign row_inc  = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
   assign cur_addr = AW'(row_q) * COLS_AW + AW'(col_q);
   assign arg      = {24'd0, fifo_dout};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         col_q     <= '0;
         clr_idx_q <= '0;
         addr_q    <= '0;
         char_q    <= '0;
         wr_val_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         clr_idx_q <= clr_idx_d;
         addr_q    <= addr_d;
         char_q    <= char_d;
         wr_val_q  <= wr_val_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               if (is_printable(fifo_dout))   state_d = WRITE;
               else if (fifo_dout == CH_FF)   state_d = CLEAR;
               else if (fifo_dout == CH_ESC)  state_d = ESC_ROW;
            end
         end
         WRITE:   if (wr_hs) state_d = IDLE;
         CLEAR:   if (wr_hs && (clr_idx_q == CLR_LAST)) state_d = IDLE;
         ESC_ROW: if (pop) state_d = ESC_COL;
         ESC_COL: if (pop) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write-port values are computed one cycle ahead so the port itself is driven by flops.
   always_comb begin
      row_d     = row_q;
      col_d     = col_q;
      clr_idx_d = clr_idx_q;
      addr_d    = addr_q;
      char_d    = char_q;
      wr_val_d  = (state_d == WRITE) || (state_d == CLEAR);
      case (state_q)
         IDLE: begin
            if (pop) begin
               if (is_printable(fifo_dout)) begin
                  addr_d = cur_addr;
                  char_d = fifo_dout;
               end else if (fifo_dout == CH_CR) begin
                  col_d = '0;
               end else if (fifo_dout == CH_LF) begin
                  col_d = '0;
                  row_d = row_inc;
               end else if (fifo_dout == CH_FF) begin
                  clr_idx_d = '0;
                  addr_d    = '0;
                  char_d    = CH_SPACE;
               end
            end
         end
         WRITE: begin
            if (wr_hs) begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_inc;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end
         CLEAR: begin
            if (wr_hs) begin
               if (clr_idx_q == CLR_LAST) begin
                  row_d = '0;
                  col_d = '0;
               end else begin
                  clr_idx_d = clr_idx_q + AW'(1);
                  addr_d    = clr_idx_q + AW'(1);
               end
            end
         end
         ESC_ROW: begin
            if (pop) row_d = (arg > ROW_MAX) ? ROW_LAST : RW'(fifo_dout);
         end
         ESC_COL: begin
            if (pop) col_d = (arg > COL_MAX) ? COL_LAST : CW'(fifo_dout);
         end
         default: ;
      endcase
   end

   // Set events take priority over a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         if (rx_val && fifo_full && !pop) overflow_q <= 1'b1;
         else if (clr_flags)              overflow_q <= 1'b0;
         if (rx_error)                    frame_err_q <= 1'b1;
         else if (clr_flags)              frame_err_q <= 1'b0;
      end
   end

   assign wr.wr_val  = wr_val_q;
   assign wr.wr_addr = addr_q;
   assign wr.wr_char = char_q;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;
   assign busy       = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_serial_lcd_cmd.sv
// Randomised and directed bench for serial_lcd_cmd against a cursor/terminal reference model.
module tb_serial_lcd_cmd;

   localparam int ROWS  = 2;
   localparam int COLS  = 16;
   localparam int CELLS = ROWS * COLS;

   logic       clk       = 1'b0;
   logic       rst_n     = 1'b0;
   logic       rx_val    = 1'b0;
   logic [7:0] rx_bits   = 8'h00;
   logic       rx_error  = 1'b0;
   logic       clr_flags = 1'b0;
   logic       ready_drv = 1'b0;
   logic       overflow;
   logic       frame_err;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int ready_mode = 1;   // 0 hold low, 1 hold high, 2 random, 3 toggle

   int         got_q[$];
   int         exp_q[$];
   logic [7:0] tx_q[$];
   int         m_row = 0;
   int         m_col = 0;
   int         m_mode = 0;

   serial_lcd_cmd_if #(.AW(5)) wr_if ();

   serial_lcd_cmd #(
      .ROWS       (ROWS),
      .COLS       (COLS),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_val    (rx_val),
      .rx_bits   (rx_bits),
      .rx_error  (rx_error),
      .clr_flags (clr_flags),
      .wr        (wr_if),
      .overflow  (overflow),
      .frame_err (frame_err),
      .busy      (busy)
   );

   assign wr_if.wr_ready = ready_drv;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       ready_drv = 1'b0;
         1:       ready_drv = 1'b1;
         2:       ready_drv = 1'($urandom_range(0, 1));
         default: ready_drv = ~ready_drv;
      endcase
   end

   // Handshake monitor and hold-stability check, sampled mid-cycle.
   logic       hold_pend = 1'b0;
   logic [4:0] hold_addr = '0;
   logic [7:0] hold_char = '0;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            checks++;
            if (wr_if.wr_val !== 1'b1 || wr_if.wr_addr !== hold_addr || wr_if.wr_char !== hold_char) begin
               failures++;
               $display("FAIL hold_stable: got val=%0b addr=%0d char=%02h, want val=1 addr=%0d char=%02h",
                        wr_if.wr_val, wr_if.wr_addr, wr_if.wr_char, hold_addr, hold_char);
            end
         end
         if (wr_if.wr_val === 1'b1 && wr_if.wr_ready === 1'b1)
            got_q.push_back(int'(wr_if.wr_addr) * 256 + int'(wr_if.wr_char));
         hold_pend = (wr_if.wr_val === 1'b1) && (wr_if.wr_ready === 1'b0);
         hold_addr = wr_if.wr_addr;
         hold_char = wr_if.wr_char;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Terminal model: linear cell index with wrap, plus the ESC argument sequence.
   task automatic model_byte(input logic [7:0] b);
      int idx;
      if (m_mode == 1) begin
         m_row  = (int'(b) > ROWS - 1) ? ROWS - 1 : int'(b);
         m_mode = 2;
      end else if (m_mode == 2) begin
         m_col  = (int'(b) > COLS - 1) ? COLS - 1 : int'(b);
         m_mode = 0;
      end else if (b >= 8'h20 && b <= 8'h7E) begin
         idx = m_row * COLS + m_col;
         exp_q.push_back(idx * 256 + int'(b));
         idx   = (idx + 1) % CELLS;
         m_row = idx / COLS;
         m_col = idx % COLS;
      end else if (b == 8'h0D) begin
         m_col = 0;
      end else if (b == 8'h0A) begin
         m_col = 0;
         m_row = (m_row + 1) % ROWS;
      end else if (b == 8'h0C) begin
         for (int i = 0; i < CELLS; i++) exp_q.push_back(i * 256 + 32);
         m_row = 0;
         m_col = 0;
      end else if (b == 8'h1B) begin
         m_mode = 1;
      end
   endtask

   task automatic send_q();
      foreach (tx_q[i]) begin
         rx_val  = 1'b1;
         rx_bits = tx_q[i];
         step(1);
      end
      rx_val = 1'b0;
   endtask

   task automatic model_q(input int n);
      for (int i = 0; i < n && i < tx_q.size(); i++) model_byte(tx_q[i]);
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         step(1);
         n++;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, want 0", name, busy, budget);
      end
   endtask

   task automatic compare_writes(input string name);
      int n;
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d writes, want %0d", name, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got_q[i] != exp_q[i]) begin
            failures++;
            $display("FAIL %s_write[%0d]: got addr=%0d char=%02h, want addr=%0d char=%02h",
                     name, i, got_q[i] / 256, got_q[i] % 256, exp_q[i] / 256, exp_q[i] % 256);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ready_mode = 1;
      step(3);
      checks += 6;
      if (wr_if.wr_val !== 1'b0)  begin failures++; $display("FAIL reset_wr_val: got %0b want 0", wr_if.wr_val); end
      if (wr_if.wr_addr !== 5'd0) begin failures++; $display("FAIL reset_wr_addr: got %0d want 0", wr_if.wr_addr); end
      if (wr_if.wr_char !== 8'd0) begin failures++; $display("FAIL reset_wr_char: got %02h want 00", wr_if.wr_char); end
      if (overflow !== 1'b0)      begin failures++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
      if (frame_err !== 1'b0)     begin failures++; $display("FAIL reset_frame_err: got %0b want 0", frame_err); end
      if (busy !== 1'b0)          begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
      rst_n = 1'b1;
      step(1);
   endtask

   task automatic test_hi();
      rx_val  = 1'b1;
      rx_bits = "H";
      step(1);
      rx_bits = "i";
      step(1);
      rx_val = 1'b0;
      checks++;
      if (wr_if.wr_val !== 1'b1 || wr_if.wr_addr !== 5'd0 || wr_if.wr_char !== "H") begin
         failures++;
         $display("FAIL hi_latency: got val=%0b addr=%0d char=%02h, want val=1 addr=0 char=48",
                  wr_if.wr_val, wr_if.wr_addr, wr_if.wr_char);
      end
      model_byte("H");
      model_byte("i");
      wait_idle("hi", 20);
      tx_q = '{"c"};
      send_q();
      model_q(1);
      wait_idle("hi_c", 20);
      compare_writes("hi");
   endtask

   task automatic test_esc_wrap();
      tx_q = '{8'h1B, 8'd1, 8'd15, "A", "B"};
      send_q();
      model_q(5);
      wait_idle("esc", 30);
      compare_writes("esc_wrap");
      tx_q = '{8'h1B, 8'd9, 8'd99, "q"};
      send_q();
      model_q(4);
      wait_idle("esc_clamp", 30);
      compare_writes("esc_clamp");
   endtask

   task automatic test_clear();
      ready_mode = 3;
      tx_q = '{8'h0C};
      send_q();
      model_q(1);
      wait_idle("clear", 300);
      compare_writes("clear");
      ready_mode = 1;
      tx_q = '{"Z"};
      send_q();
      model_q(1);
      wait_idle("clear_z", 20);
      compare_writes("clear_z");
   endtask

   task automatic test_overflow();
      ready_mode = 0;
      step(2);
      tx_q = '{"a", "b", "c", "d", "e", "f"};
      send_q();
      model_q(5);
      step(1);
      checks += 3;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %0b want 1", overflow); end
      if (wr_if.wr_val !== 1'b1 || wr_if.wr_char !== "a") begin
         failures++;
         $display("FAIL ovf_stall: got val=%0b char=%02h, want val=1 char=61", wr_if.wr_val, wr_if.wr_char);
      end
      if (busy !== 1'b1) begin failures++; $display("FAIL ovf_busy: got %0b want 1", busy); end
      ready_mode = 1;
      wait_idle("ovf", 40);
      compare_writes("ovf");
      clr_flags = 1'b1;
      step(1);
      clr_flags = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
   endtask

   task automatic test_flags_reset();
      rx_error  = 1'b1;
      clr_flags = 1'b1;
      step(1);
      rx_error  = 1'b0;
      clr_flags = 1'b0;
      checks++;
      if (frame_err !== 1'b1) begin failures++; $display("FAIL ferr_set_wins: got %0b want 1", frame_err); end
      clr_flags = 1'b1;
      step(1);
      clr_flags = 1'b0;
      checks++;
      if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear: got %0b want 0", frame_err); end

      ready_mode = 1;
      tx_q = '{8'h0C};
      send_q();
      step(4);
      checks++;
      if (wr_if.wr_val !== 1'b1 || wr_if.wr_char !== 8'h20) begin
         failures++;
         $display("FAIL mid_clear: got val=%0b char=%02h, want val=1 char=20", wr_if.wr_val, wr_if.wr_char);
      end
      tx_q = '{"m"};
      send_q();
      step(1);
      #2;
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (wr_if.wr_val !== 1'b0)  begin failures++; $display("FAIL rst_wr_val: got %0b want 0", wr_if.wr_val); end
      if (busy !== 1'b0)          begin failures++; $display("FAIL rst_busy: got %0b want 0", busy); end
      if (wr_if.wr_addr !== 5'd0) begin failures++; $display("FAIL rst_addr: got %0d want 0", wr_if.wr_addr); end
      step(1);
      got_q.delete();
      exp_q.delete();
      m_row = 0;
      m_col = 0;
      m_mode = 0;
      rst_n = 1'b1;
      step(1);
      tx_q = '{"k"};
      send_q();
      model_q(1);
      wait_idle("post_rst", 20);
      compare_writes("post_rst");
   endtask

   task automatic test_ctrl();
      tx_q = '{8'h0D, 8'h0A, 8'h07, 8'h80};
      send_q();
      model_q(4);
      wait_idle("ctrl", 30);
      compare_writes("ctrl_nowrite");
      tx_q = '{"x"};
      send_q();
      model_q(1);
      wait_idle("ctrl_x", 20);
      compare_writes("ctrl_x");
   endtask

   task automatic test_random();
      int r;
      int n_items;
      int gap;
      ready_mode = 2;
      for (int g = 0; g < 40; g++) begin
         wait_idle("rand", 400);
         tx_q.delete();
         n_items = $urandom_range(1, 3);
         for (int k = 0; k < n_items; k++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      begin if (tx_q.size() < 5) tx_q.push_back(8'($urandom_range(32, 126))); end
            else if (r < 68) begin if (tx_q.size() < 5) tx_q.push_back(8'h0D); end
            else if (r < 76) begin if (tx_q.size() < 5) tx_q.push_back(8'h0A); end
            else if (r < 78) begin if (tx_q.size() < 5) tx_q.push_back(8'h0C); end
            else if (r < 90) begin
               if (tx_q.size() <= 2) begin
                  tx_q.push_back(8'h1B);
                  tx_q.push_back(8'($urandom_range(0, 40)));
                  tx_q.push_back(8'($urandom_range(0, 40)));
               end
            end else begin
               if (tx_q.size() < 5) tx_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
            end
         end
         foreach (tx_q[i]) begin
            rx_val  = 1'b1;
            rx_bits = tx_q[i];
            step(1);
            rx_val = 1'b0;
            gap = $urandom_range(0, 2);
            step(gap);
         end
         model_q(tx_q.size());
      end
      wait_idle("rand_end", 400);
      compare_writes("rand");
      checks++;
      if (overflow !== 1'b0 || frame_err !== 1'b0) begin
         failures++;
         $display("FAIL rand_flags: got overflow=%0b frame_err=%0b, want 0 0", overflow, frame_err);
      end
      ready_mode = 1;
   endtask

   initial begin
      #1;
      test_reset();
      test_hi();
      test_esc_wrap();
      test_clear();
      test_overflow();
      test_flags_reset();
      test_ctrl();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
